// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Start/pause/clear sequencer for a 4-digit BCD up/down stopwatch
//            with multiplexed seven-segment digit scan and leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_scan,
    input  logic        tick_count,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        mode_down,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        dir_q, dir_d;
    logic [1:0]  idx_q;
    logic [3:0]  an_q, digit_q;
    logic        blank_q, running_q, done_q;

    logic [15:0] step_w;
    logic [15:0] clamp_w;
    logic        carry_w;
    logic        slot_blank_w;

    // One BCD step in the latched direction, rippling carry/borrow upward
    always_comb begin
        step_w  = count_q;
        carry_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry_w) begin
                if (!dir_q) begin
                    if (count_q[4*i +: 4] >= 4'd9) begin
                        step_w[4*i +: 4] = 4'd0;
                    end else begin
                        step_w[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry_w          = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        step_w[4*i +: 4] = 4'd9;
                    end else begin
                        step_w[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry_w          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        clamp_w = load_val;
        for (int i = 0; i < 4; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                clamp_w[4*i +: 4] = 4'd9;
            end
        end
    end

    // Slot 0 always lit so a zero count still shows a single 0
    always_comb begin
        slot_blank_w = 1'b0;
        if (LZ_BLANK) begin
            case (idx_q)
                2'd1:    slot_blank_w = (count_q[15:4]  == 12'd0);
                2'd2:    slot_blank_w = (count_q[15:8]  == 8'd0);
                2'd3:    slot_blank_w = (count_q[15:12] == 4'd0);
                default: slot_blank_w = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        if (btn_clear) begin
            state_d = S_IDLE;
            count_d = 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        count_d = clamp_w;
                    end
                    if (btn_start && !(mode_down && (count_q == 16'd0))) begin
                        state_d = S_RUN;
                        dir_d   = mode_down;
                    end
                end
                S_RUN: begin
                    if (tick_count) begin
                        count_d = step_w;
                    end
                    if (tick_count && dir_q && (step_w == 16'd0)) begin
                        state_d = S_EXPIRED;
                    end else if (btn_start) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (btn_start) begin
                        state_d = S_RUN;
                    end
                end
                S_EXPIRED: begin
                    if (btn_start) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= 16'd0;
            dir_q     <= 1'b0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1111;
            digit_q   <= 4'd0;
            blank_q   <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_EXPIRED);
            if (tick_scan) begin
                idx_q <= idx_q + 2'd1;
            end
            digit_q <= count_q[{idx_q, 2'b00} +: 4];
            blank_q <= slot_blank_w;
            an_q    <= slot_blank_w ? 4'b1111 : ~(4'b0001 << idx_q);
        end
    end

    assign an      = an_q;
    assign digit   = digit_q;
    assign blank   = blank_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Scoreboard bench for stopwatch_ctrl; counts are read back by
//            scanning all four slots and compared against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_scan = 1'b0;
    logic        tick_count = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        mode_down = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'd0;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        blank;
    logic        running;
    logic        done;

    always #10 clk = ~clk;

    stopwatch_ctrl #(.LZ_BLANK(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_scan  (tick_scan),
        .tick_count (tick_count),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .mode_down  (mode_down),
        .load       (load),
        .load_val   (load_val),
        .an         (an),
        .digit      (digit),
        .blank      (blank),
        .running    (running),
        .done       (done)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] an4;
        logic [3:0]  bl;
        logic        run;
        logic        dn;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       obs_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] tb_idx = 2'd0;

    function automatic rec_t model(input logic [15:0] c, input logic r, input logic d);
        rec_t m;
        m.cnt = c;
        m.run = r;
        m.dn  = d;
        for (int i = 0; i < 4; i++) begin
            m.bl[i] = (i > 0) && ((c >> (4*i)) == 16'd0);
            m.an4[4*i +: 4] = m.bl[i] ? 4'b1111 : ~(4'b0001 << i);
        end
        return m;
    endfunction

    // One-cycle pulse on the chosen inputs followed by one quiet cycle
    task automatic strobe(input logic st, input logic cl, input logic tc,
                          input logic ld, input logic ts);
        @(posedge clk); #1;
        btn_start = st; btn_clear = cl; tick_count = tc; load = ld; tick_scan = ts;
        if (ts) tb_idx = tb_idx + 2'd1;
        @(posedge clk); #1;
        btn_start = 1'b0; btn_clear = 1'b0; tick_count = 1'b0; load = 1'b0; tick_scan = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic observe();
        rec_t o;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            o.cnt[4*tb_idx +: 4] = digit;
            o.an4[4*tb_idx +: 4] = an;
            o.bl[tb_idx]         = blank;
        end
        o.run = running;
        o.dn  = done;
        obs_q.push_back(o);
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rec_t e, o;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({an, digit, blank, running, done} !== {4'b1111, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got an=%b digit=%h blank=%b run=%b done=%b, want 1111/0/1/0/0",
                     an, digit, blank, running, done);
        end
        rst_n = 1'b1;
        tb_idx = 2'd0;
        for (int k = 0; k < 8; k++) begin
            strobe(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tests_run++;
            if (tb_idx == 2'd0) begin
                if ({an, digit, blank} !== {4'b1110, 4'd0, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL idle_scan slot0: got an=%b digit=%h blank=%b, want 1110/0/0", an, digit, blank);
                end
            end else if ({an, digit, blank} !== {4'b1111, 4'd0, 1'b1}) begin
                tests_failed++;
                $display("FAIL idle_scan slot%0d: got an=%b digit=%h blank=%b, want 1111/0/1",
                         tb_idx, an, digit, blank);
            end
        end
        exp_q.push_back(model(16'h0000, 1'b0, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL reset_sb: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_up_carry();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h0999);
        mode_down = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h1000, 1'b1, 1'b0));
        observe();
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h9999);
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b1, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL up_carry: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_down_expiry();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h0002);
        mode_down = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_down = 1'b0;
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0001, 1'b1, 1'b0));
        observe();
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({running, done} !== 2'b01) begin
            tests_failed++;
            $display("FAIL expiry_edge: got run=%b done=%b, want run=0 done=1", running, done);
        end
        exp_q.push_back(model(16'h0000, 1'b0, 1'b1));
        observe();
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b0, 1'b1));
        observe();
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b0, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL down_expiry: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_pause_collision();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h0005);
        mode_down = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0006, 1'b0, 1'b0));
        observe();
        strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0006, 1'b1, 1'b0));
        observe();
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0007, 1'b1, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL pause_collision: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_clear_priority();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h0042);
        mode_down = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b0, 1'b0));
        observe();
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_load(16'h12F4);
        exp_q.push_back(model(16'h0000, 1'b1, 1'b0));
        observe();
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h12F4);
        exp_q.push_back(model(16'h1294, 1'b0, 1'b0));
        observe();
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mode_down = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_down = 1'b0;
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b0, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL clear_priority: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_mid_reset();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h0123);
        mode_down = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick_count = 1'b1;
        @(posedge clk); #1;
        tick_count = 1'b0;
        tests_run++;
        if ({an, digit, blank, running, done} !== {4'b1111, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset: got an=%b digit=%h blank=%b run=%b done=%b, want 1111/0/1/0/0",
                     an, digit, blank, running, done);
        end
        rst_n = 1'b1;
        tb_idx = 2'd0;
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0000, 1'b0, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL mid_reset_sb: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_load(16'h1000);
        mode_down = 1'b1;
        strobe(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_down = 1'b0;
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0999, 1'b1, 1'b0));
        observe();
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(model(16'h0997, 1'b1, 1'b0));
        observe();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL back_to_back: got cnt=%h an=%h bl=%b run=%b done=%b, want cnt=%h an=%h bl=%b run=%b done=%b",
                         o.cnt, o.an4, o.bl, o.run, o.dn, e.cnt, e.an4, e.bl, e.run, e.dn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_carry();
        test_down_expiry();
        test_pause_collision();
        test_clear_priority();
        test_mid_reset();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got exp=%0d obs=%0d leftover, want 0/0", exp_q.size(), obs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
